// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory sequencer shared by core fetch and a program loader
// Optional checksum accumulator: define IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int FLUSH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       fetch_pc,
    output logic [31:0]       instr,
    output logic              core_hold_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err,
    output logic [31:0]       ld_csum,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH} state_t;

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);
    localparam logic [3:0]      L_FLAST = 4'(FLUSH_CYC - 1);

    state_t          r_state;
    logic [ADDR_W:0] r_wptr;
    logic [3:0]      r_fcnt;
    logic [ADDR_W:0] r_ld_count;
    logic            r_ld_err;

    logic w_load;
    logic w_room;
    logic w_unused_pc;

    assign w_load      = (r_state == S_LOAD);
    assign w_room      = (r_wptr < L_DEPTH);
    assign w_unused_pc = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0]};

    assign instr       = mem_rdata;
    assign core_hold_n = (r_state == S_RUN);
    assign ld_ready    = w_load;
    assign mem_we      = w_load & ld_valid & w_room;
    assign mem_wdata   = ld_data;
    assign mem_addr    = w_load ? r_wptr[ADDR_W-1:0] : fetch_pc[ADDR_W+1:2];
    assign ld_count    = r_ld_count;
    assign ld_err      = r_ld_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wptr     <= '0;
            r_fcnt     <= '0;
            r_ld_count <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ld_start) begin
                        r_state    <= S_LOAD;
                        r_wptr     <= '0;
                        r_ld_count <= '0;
                        r_ld_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        // Beats past the end are acknowledged but dropped; wptr saturates at DEPTH.
                        if (w_room) begin
                            r_wptr     <= r_wptr + L_ONE;
                            r_ld_count <= r_ld_count + L_ONE;
                        end else begin
                            r_ld_err <= 1'b1;
                        end
                        if (ld_last) begin
                            r_state <= S_FLUSH;
                            r_fcnt  <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_fcnt <= r_fcnt + 4'd1;
                    if (r_fcnt == L_FLAST) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_ld_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_csum <= '0;
        end else if ((r_state == S_RUN) && ld_start) begin
            r_ld_csum <= '0;
        end else if (mem_we) begin
            r_ld_csum <= r_ld_csum + ld_data;
        end
    end

    assign ld_csum = r_ld_csum;
`else
    assign ld_csum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

    localparam int DEPTH     = 64;
    localparam int ADDR_W    = 6;
    localparam int FLUSH_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       fetch_pc;
    logic [31:0]       instr;
    logic              core_hold_n;
    logic              ld_start;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              ld_err;
    logic [31:0]       ld_csum;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [DEPTH];
    logic        preload = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .instr(instr),
        .core_hold_n(core_hold_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_count(ld_count), .ld_err(ld_err), .ld_csum(ld_csum),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input int exp_addr, input logic exp_we);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        #1;
        chk("beat_ready", 32'(ld_ready), 32'd1);
        chk("beat_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) chk("beat_addr", 32'(mem_addr), 32'(exp_addr));
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic check_flush(input string name, input logic start_in_flush);
        for (int i = 0; i < FLUSH_CYC; i++) begin
            chk({name, "_hold_low"}, 32'(core_hold_n), 32'd0);
            chk({name, "_flush_ready"}, 32'(ld_ready), 32'd0);
            ld_start = start_in_flush && (i == 0);
            tick();
            ld_start = 1'b0;
        end
        chk({name, "_hold_release"}, 32'(core_hold_n), 32'd1);
    endtask

    typedef struct {
        logic [31:0]       pc;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] sum;
        int          bad;

        vecs[0] = '{32'h0000_000C, 6'd3};
        vecs[1] = '{32'h0000_000F, 6'd3};
        vecs[2] = '{32'h0000_0100, 6'd0};
        vecs[3] = '{32'h0000_00FC, 6'd63};
        vecs[4] = '{32'hFFFF_FFF8, 6'd62};
        vecs[5] = '{32'h0000_0014, 6'd5};

        rst_n = 1'b0; fetch_pc = '0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0;
        tick();
        tick();
        preload = 1'b0;
        chk("rst_hold", 32'(core_hold_n), 32'd1);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_count", 32'(ld_count), 32'd0);
        chk("rst_err", 32'(ld_err), 32'd0);
        chk("rst_csum", ld_csum, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            fetch_pc = vecs[i].pc;
            #1;
            chk("run_addr", 32'(mem_addr), 32'(vecs[i].addr));
            chk("run_instr", instr, 32'hA000_0000 + 32'(vecs[i].addr));
            chk("run_hold", 32'(core_hold_n), 32'd1);
            chk("run_ready", 32'(ld_ready), 32'd0);
            chk("run_we", 32'(mem_we), 32'd0);
            tick();
        end

        // Basic 3-beat load
        chk("pre_start_hold", 32'(core_hold_n), 32'd1);
        pulse_start();
        chk("load_hold", 32'(core_hold_n), 32'd0);
        beat(32'h11, 1'b0, 0, 1'b1);
        beat(32'h22, 1'b0, 1, 1'b1);
        beat(32'h33, 1'b1, 2, 1'b1);
        check_flush("basic", 1'b0);
        chk("basic_m0", mem[0], 32'h11);
        chk("basic_m1", mem[1], 32'h22);
        chk("basic_m2", mem[2], 32'h33);
        chk("basic_m3", mem[3], 32'hA000_0003);
        chk("basic_count", 32'(ld_count), 32'd3);
        chk("basic_err", 32'(ld_err), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk("basic_csum", ld_csum, 32'h66);
`else
        chk("basic_csum", ld_csum, 32'h0);
`endif

        // Gapped load with ld_start pulses in LOAD and FLUSH
        pulse_start();
        beat(32'hA1, 1'b0, 0, 1'b1);
        ld_start = 1'b1;
        #1;
        chk("gap_we", 32'(mem_we), 32'd0);
        chk("gap_addr", 32'(mem_addr), 32'd1);
        tick();
        ld_start = 1'b0;
        beat(32'hA2, 1'b0, 1, 1'b1);
        tick();
        chk("gap2_we", 32'(mem_we), 32'd0);
        tick();
        beat(32'hA3, 1'b1, 2, 1'b1);
        check_flush("gap", 1'b1);
        chk("gap_no_restart", 32'(ld_ready), 32'd0);
        chk("gap_m0", mem[0], 32'hA1);
        chk("gap_m1", mem[1], 32'hA2);
        chk("gap_m2", mem[2], 32'hA3);
        chk("gap_count", 32'(ld_count), 32'd3);
        tick();
        chk("gap_hold_stays", 32'(core_hold_n), 32'd1);

        // Overflow: DEPTH+2 beats
        pulse_start();
        sum = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) sum = sum + 32'h1000_0000 + 32'(i);
            beat(32'h1000_0000 + 32'(i), i == DEPTH + 1, i, i < DEPTH);
        end
        check_flush("ovf", 1'b0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h1000_0000 + 32'(i)) bad++;
        chk("ovf_mem_bad", 32'(bad), 32'd0);
        chk("ovf_count", 32'(ld_count), 32'(DEPTH));
        chk("ovf_err", 32'(ld_err), 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk("ovf_csum", ld_csum, sum);
`else
        chk("ovf_csum", ld_csum, 32'h0);
`endif
        tick();
        chk("ovf_err_sticky", 32'(ld_err), 32'd1);

        // Reset mid-load after 5 beats
        pulse_start();
        chk("rl_err_cleared", 32'(ld_err), 32'd0);
        for (int i = 0; i < 5; i++) beat(32'hB0 + 32'(i), 1'b0, i, 1'b1);
        chk("rl_count5", 32'(ld_count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rl_hold_async", 32'(core_hold_n), 32'd1);
        chk("rl_ready_async", 32'(ld_ready), 32'd0);
        chk("rl_count_async", 32'(ld_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            chk("rl_keep", instr, (i < 5) ? 32'hB0 + 32'(i) : 32'h1000_0005);
        end
        chk("rl_hold_run", 32'(core_hold_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencer that owns the single-port instruction memory and shares it between the core's fetch path and a boot/debug program loader. In normal operation it passes the fetch PC straight to the memory. On a load request it holds the core, streams loader words into consecutive memory locations from word 0, then keeps the core held for a fixed flush window and releases it to restart at PC 0.

## Interface
- DEPTH, 64, instruction memory depth in 32-bit words
- ADDR_W, 6, word-address width; must equal log2(DEPTH)
- FLUSH_CYC, 4, cycles the core stays held after the last load beat (1..15)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_pc  in  32  core byte PC
- instr  out  32  instruction to core; equals mem_rdata
- core_hold_n  out  1  low holds the core in reset/stall; high lets it run
- ld_start  in  1  one-cycle pulse requesting a program load
- ld_valid  in  1  loader data beat valid
- ld_data  in  32  loader data word
- ld_last  in  1  marks the final beat; sampled with ld_valid
- ld_ready  out  1  controller accepts a beat this cycle
- ld_count  out  ADDR_W+1  words written in the current or last load
- ld_err  out  1  sticky overflow flag
- ld_csum  out  32  additive checksum of loaded words (see Configuration)
- mem_addr  out  ADDR_W  word address to the memory
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  asynchronous memory read data

## Operation
- States: RUN, LOAD, FLUSH. Reset state RUN.
- RUN: mem_addr = fetch_pc[ADDR_W+1:2]; mem_we=0; ld_ready=0; core_hold_n=1. fetch_pc[1:0] and bits above ADDR_W+1 are ignored.
- RUN and ld_start=1: next state LOAD; wptr←0; ld_count←0; ld_err←0; ld_csum←0.
- LOAD: core_hold_n=0; ld_ready=1; mem_addr=wptr; mem_wdata=ld_data.
- LOAD beat accepted (ld_valid and wptr<DEPTH): mem_we=1; wptr and ld_count increment by 1.
- When wptr=DEPTH, extra beats are still acknowledged (ld_ready=1) but mem_we=0, and ld_err←1. wptr saturates at DEPTH.
- LOAD and ld_valid and ld_last: the beat is processed as above, then the next state is FLUSH with fcnt←0.
- FLUSH: core_hold_n=0; ld_ready=0; mem_we=0; mem_addr=fetch_pc[ADDR_W+1:2]. fcnt increments each cycle. At fcnt=FLUSH_CYC-1 the next state is RUN.
- ld_start is ignored in LOAD and FLUSH.
- ld_count, ld_err and ld_csum hold their values in RUN until the next ld_start.

## Timing
- Reset values: state RUN, wptr 0, fcnt 0, ld_count 0, ld_err 0, ld_csum 0.
- Outputs during reset: core_hold_n=1, ld_ready=0, mem_we=0.
- instr is combinational from mem_rdata; fetch has zero added latency.
- ld_ready, mem_we, mem_addr and mem_wdata are combinational from state, wptr and ld_valid. The memory writes on the rising clk edge of the accepting cycle.
- ld_start is sampled at the edge, so core_hold_n falls in the cycle after the pulse.
- After the last beat's edge, core_hold_n stays low for exactly FLUSH_CYC cycles, then rises.
- Asynchronous reset during LOAD or FLUSH returns immediately to RUN with core_hold_n=1. Memory contents already written are kept.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined: ld_csum accumulates the 32-bit wrap-around sum of every word actually written (mem_we=1). Dropped overflow beats are not summed.
- IMEM_LOAD_CHECKSUM_EN not defined: no accumulator is built and ld_csum is tied to 0.

## Test plan
- Reset, then fetch_pc=0x0000000C -> mem_addr=3, instr=mem_rdata, core_hold_n=1, ld_ready=0.
- ld_start, then 3 beats 0x11,0x22,0x33 with ld_last on the third -> words 0..2 written, ld_count=3, ld_err=0. core_hold_n goes low the cycle after ld_start and returns high FLUSH_CYC cycles after the third beat. ld_csum=0x66 with the macro, 0 without.
- Loader deasserts ld_valid between beats -> no write in gap cycles; wptr stays; addresses stay contiguous.
- DEPTH+2 beats, last flagged -> DEPTH writes, 2 beats acknowledged but not written, ld_err=1, ld_count=DEPTH, then FLUSH→RUN.
- ld_start pulsed during LOAD and during FLUSH -> no restart; ld_count and flush timing unchanged.
- rst_n low for 1 cycle mid-LOAD after 5 beats -> RUN, core_hold_n=1, ld_count=0. Words 0..4 retain their written data.
